// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: operands are latched through a valid/ready handshake,
// summed DIGIT bits per clock (LSB first), and the result is held until the consumer takes it.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned K  = WIDTH / DIGIT;
  localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: WIDTH must be a non-zero multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] da;
  logic [DIGIT-1:0] db;
  logic [DIGIT:0]   slice;
  logic             msb_cin;

  // One DIGIT-wide adder slice; the carry into its top bit feeds the overflow detect
  always_comb begin
    da      = a_q[cnt*DIGIT +: DIGIT];
    db      = b_q[cnt*DIGIT +: DIGIT];
    slice   = {1'b0, da} + {1'b0, db} + {{DIGIT{1'b0}}, c_q};
    msb_cin = da[DIGIT-1] ^ db[DIGIT-1] ^ slice[DIGIT-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is A + ~B + ~borrow, so carry_out=1 means no borrow
            a_q      <= a;
            b_q      <= sub ? ~b : b;
            c_q      <= sub ? ~carry_in : carry_in;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[cnt*DIGIT +: DIGIT] <= slice[DIGIT-1:0];
          c_q <= slice[DIGIT];
          cnt <= cnt + 1'b1;
          if (cnt == CW'(K - 1)) begin
            carry_out <= slice[DIGIT];
            overflow  <= msb_cin ^ slice[DIGIT];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vector table, handshake corner cases,
// and random operations against an arithmetic reference model (DIGIT=1 and DIGIT=4).
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv8, iv4;
  logic       rdy8, rdy4;
  logic [7:0] a, b;
  logic       carry_in, sub, out_ready;
  logic       ov8v, ov4v;
  logic [7:0] sum8, sum4;
  logic       co8, co4, of8, of4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8), .a(a), .b(b),
    .carry_in(carry_in), .sub(sub), .out_valid(ov8v), .out_ready(out_ready),
    .sum(sum8), .carry_out(co8), .overflow(of8)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy4), .a(a), .b(b),
    .carry_in(carry_in), .sub(sub), .out_valid(ov4v), .out_ready(out_ready),
    .sum(sum4), .carry_out(co4), .overflow(of4)
  );

  typedef struct {
    logic       use4;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       ov;
    string      name;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations
  function automatic void model(input logic [7:0] ma, input logic [7:0] mb, input logic mc,
                                input logic ms, output logic [7:0] s, output logic co,
                                output logic ov);
    int ua, ub, sa, sb, ci, r, sr;
    ua = ma;
    ub = mb;
    sa = $signed(ma);
    sb = $signed(mb);
    ci = mc;
    if (!ms) begin
      r  = ua + ub + ci;
      sr = sa + sb + ci;
      co = (r > 255);
    end else begin
      r  = ua - ub - ci;
      sr = sa - sb - ci;
      co = (r >= 0);
    end
    s  = r[7:0];
    ov = (sr > 127) || (sr < -128);
  endfunction

  task automatic do_op(input logic use4, input logic [7:0] op_a, input logic [7:0] op_b,
                       input logic cin, input logic op_sub, input logic [7:0] es,
                       input logic eco, input logic eov, input string nm);
    int n;
    int k;
    k = use4 ? 2 : 8;
    check({nm, " in_ready before"}, use4 ? rdy4 : rdy8, 1);
    a = op_a; b = op_b; carry_in = cin; sub = op_sub;
    if (use4) iv4 = 1'b1; else iv8 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0; iv8 = 1'b0;
    n = 0;
    while (n < 40 && !(use4 ? ov4v : ov8v)) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, " latency"}, n, k);
    check({nm, " sum"}, use4 ? sum4 : sum8, es);
    check({nm, " carry_out"}, use4 ? co4 : co8, eco);
    check({nm, " overflow"}, use4 ? of4 : of8, eov);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, " out_valid after transfer"}, use4 ? ov4v : ov8v, 0);
    check({nm, " in_ready after transfer"}, use4 ? rdy4 : rdy8, 1);
  endtask

  vec_t vecs[5];

  initial begin
    logic [7:0] hs;
    logic       hco, hov;
    logic [7:0] ra, rb;
    logic       rc, rs;
    int         n;

    vecs[0] = '{1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "add ff+01"};
    vecs[1] = '{1'b0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "add 7f+01"};
    vecs[2] = '{1'b0, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, "sub 05-07"};
    vecs[3] = '{1'b0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub 80-01"};
    vecs[4] = '{1'b1, 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "d4 add a5+5a+1"};

    rst = 1'b1; iv8 = 1'b1; iv4 = 1'b1; out_ready = 1'b0;
    a = 8'h33; b = 8'h44; carry_in = 1'b1; sub = 1'b0;

    // Reset held for three cycles while operands are offered
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset out_valid", ov8v, 0);
      check("reset sum", sum8, 0);
      check("reset carry_out", co8, 0);
      check("reset overflow", of8, 0);
    end
    iv8 = 1'b0; iv4 = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready after reset", rdy8, 1);
    check("in_ready after reset d4", rdy4, 1);

    for (int i = 0; i < 5; i++)
      do_op(vecs[i].use4, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
            vecs[i].s, vecs[i].co, vecs[i].ov, vecs[i].name);

    // Backpressure in DONE with in_valid and operands toggling
    a = 8'h12; b = 8'h34; carry_in = 1'b0; sub = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    n = 0;
    while (n < 40 && !ov8v) begin @(posedge clk); #1; n++; end
    check("bp latency", n, 8);
    for (int i = 0; i < 5; i++) begin
      iv8 = ~iv8; a = 8'($urandom); b = 8'($urandom); sub = ~sub;
      @(posedge clk); #1;
      check("bp out_valid", ov8v, 1);
      check("bp in_ready", rdy8, 0);
      check("bp sum", sum8, 8'h46);
      check("bp carry_out", co8, 0);
      check("bp overflow", of8, 0);
    end
    iv8 = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; iv8 = 1'b0;
    check("bp out_valid after transfer", ov8v, 0);
    check("bp in_ready after transfer", rdy8, 1);
    @(posedge clk); #1;
    check("bp no accept in DONE", rdy8, 1);

    // Reset three cycles into RUN aborts the operation
    a = 8'h01; b = 8'h02; carry_in = 1'b0; sub = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort in_ready", rdy8, 1);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ov8v) n++;
    end
    check("abort no out_valid", n, 0);
    check("abort idle in_ready", rdy8, 1);

    // Random operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      model(ra, rb, rc, rs, hs, hco, hov);
      do_op(logic'(i % 3 == 0), ra, rb, rc, rs, hs, hco, hov, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor; successor to the single-bit combinational full adder.
- Latches two WIDTH-bit operands through a valid/ready handshake and processes DIGIT bits per clock, LSB digit first, through one DIGIT-bit adder slice and a registered carry.
- Presents sum, carry-out and signed overflow through an output valid/ready handshake.
- Used where area matters more than latency, and as the arithmetic core for wider datapaths in the lab design.

Parameters:
- WIDTH, 8: operand and sum width in bits; must be at least 1.
- DIGIT, 1: bits processed per cycle; WIDTH mod DIGIT must be 0, otherwise elaboration fails. K = WIDTH/DIGIT is the number of processing cycles.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- carry_in  in  1  carry-in (add) or borrow-in (sub).
- sub  in  1  0 = A+B+carry_in; 1 = A-B-carry_in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- carry_out  out  1  raw carry out of the MSB; in sub mode 1 = no borrow.
- overflow  out  1  two's-complement overflow.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state=IDLE; in_ready=1 on the first cycle after rst deasserts; out_valid=0, sum=0, carry_out=0, overflow=0; step counter=0.
- rst has priority over every other input in every state. Reset mid-RUN or mid-DONE aborts the operation with no out_valid pulse, and the result is discarded.
- IDLE: in_ready=1, out_valid=0.
  - On an edge with in_valid=1, latch A and B' = sub ? ~b : b.
  - Latch carry register c = sub ? ~carry_in : carry_in.
  - Clear the step counter; go to RUN.
- RUN: in_ready=0.
  - Each edge adds digit i of A and B' plus c; the DIGIT result bits go into sum bits [i*DIGIT +: DIGIT].
  - c takes the digit carry-out; the counter increments.
  - On the edge processing digit K-1, capture carry_out = final carry.
  - On the same edge capture overflow = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1); this is computed inside the last digit slice.
  - Then go to DONE.
- DONE: out_valid=1; sum, carry_out and overflow stay stable until the transfer.
  - On an edge with out_ready=1, go to IDLE; in_ready=1 the next cycle.
- Latency: operands accepted at edge E0; out_valid=1 in the cycle after edge E0+K, i.e. exactly K cycles after acceptance.
  - With out_ready held high, the result transfers on the next edge.
  - Minimum initiation interval: K+2 cycles.
- No overlap:
  - in_valid is ignored outside IDLE.
  - in_valid and out_ready asserted in the same cycle during DONE completes only the output transfer; the new operands are accepted in IDLE on the following edge.
- out_ready is ignored when out_valid=0.
- sum, carry_out and overflow are defined only while out_valid=1; their contents during RUN are unspecified.
- DIGIT=WIDTH: K=1; the block degenerates to a registered single-cycle adder with the same handshake.
- WIDTH=1, DIGIT=1 reproduces the full-adder truth table in the registered outputs.

Test Plan:
- Reset: assert rst for 3 cycles while driving in_valid=1 -> out_valid=0, sum=0, carry_out=0, overflow=0 throughout; in_ready=1 on the first cycle after release.
- WIDTH=8, DIGIT=1, add 8'hFF + 8'h01, carry_in=0 -> sum=8'h00, carry_out=1, overflow=0; out_valid rises exactly 8 cycles after acceptance.
- Add 8'h7F + 8'h01, carry_in=0 -> sum=8'h80, carry_out=0, overflow=1.
- Sub 8'h05 - 8'h07, carry_in=0 -> sum=8'hFE, carry_out=0 (borrow), overflow=0.
  - Then sub 8'h80 - 8'h01 -> sum=8'h7F, carry_out=1, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and operands -> outputs stable, in_ready=0, no new acceptance.
  - Then raise out_ready -> one transfer; in_ready=1 the next cycle.
- Reset 3 cycles into RUN -> IDLE, no out_valid.
  - Then a DIGIT=4 instance adds 8'hA5 + 8'h5A, carry_in=1 -> sum=8'h00, carry_out=1, overflow=0; out_valid 2 cycles after acceptance.
